// File: rtl/mem_access_unit.sv
// LDR/STR memory-stage controller: req/ack to data memory, stall held while busy; wb pulse at ack+1, store ready at ack+1.
// Optional MEM_ALIGN_CHECK_EN: misaligned word ops raise align_fault instead of issuing a request.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_load,
    input  logic        op_byte,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [3:0]  op_rd,
    output logic        op_ready,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_timeout
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        load_q;
    logic [1:0]  lane_q;
    logic [3:0]  rd_q;
    logic        accept, misalign, issue, limit_hit, ack_hit, timeout_hit;
    logic [31:0] lane_data;

    assign op_ready = (state == IDLE);
    assign stall    = (state != IDLE);
    assign accept   = op_ready & op_valid;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ~op_byte & (op_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign issue       = accept & ~misalign;
    assign limit_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt == LIMIT);
    assign ack_hit     = (state == REQ) & mem_ack;
    assign timeout_hit = (state == REQ) & ~mem_ack & limit_hit;

    always_comb begin
        lane_data = 32'd0;
        case (lane_q)
            2'd0: lane_data = {24'd0, mem_rdata[7:0]};
            2'd1: lane_data = {24'd0, mem_rdata[15:8]};
            2'd2: lane_data = {24'd0, mem_rdata[23:16]};
            2'd3: lane_data = {24'd0, mem_rdata[31:24]};
            default: lane_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Ack beats the timeout when both land in the same cycle.
                if (mem_ack) begin
                    state_nxt = load_q ? RESP : IDLE;
                end else if (limit_hit) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= 8'd0;
            load_q      <= 1'b0;
            lane_q      <= 2'd0;
            rd_q        <= 4'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'd0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 4'd0;
            wb_data     <= 32'd0;
            mem_timeout <= 1'b0;
        end else begin
            wb_valid    <= ack_hit & load_q;
            mem_timeout <= timeout_hit;
            if (issue) begin
                load_q    <= op_load;
                lane_q    <= op_addr[1:0];
                rd_q      <= op_rd;
                wait_cnt  <= 8'd0;
                mem_req   <= 1'b1;
                mem_we    <= ~op_load;
                mem_addr  <= {op_addr[31:2], 2'b00};
                mem_be    <= op_byte ? (4'b0001 << op_addr[1:0]) : 4'b1111;
                mem_wdata <= op_byte ? {4{op_wdata[7:0]}} : op_wdata;
            end
            if (state == REQ) begin
                if (mem_ack || limit_hit) begin
                    mem_req <= 1'b0;
                end
                if (!mem_ack) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (mem_ack && load_q) begin
                    wb_rd   <= rd_q;
                    wb_data <= lane_q == 2'd0 && mem_be == 4'b1111 ? mem_rdata :
                               (mem_be == 4'b1111 ? mem_rdata : lane_data);
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_fault <= 1'b0;
        end else begin
            align_fault <= accept & misalign;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level reference model.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_load, op_byte;
    logic [31:0] op_addr, op_wdata;
    logic [3:0]  op_rd;
    logic        op_ready, stall, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_timeout;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_load(op_load), .op_byte(op_byte),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
        .op_ready(op_ready), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_timeout(mem_timeout)
`ifdef MEM_ALIGN_CHECK_EN
        , .align_fault(align_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ack_at: REQ cycle (1-based) on which memory acks; 0 or >TO means never.
    task automatic do_op(input bit ld, input bit by, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] rd,
                         input int ack_at, input logic [31:0] rdata);
        logic [3:0]  be;
        logic [31:0] wd, wbd;
        int          sh;
        bit          acked;
        be  = by ? 4'(1 << addr[1:0]) : 4'hF;
        wd  = by ? 32'(wdata[7:0]) * 32'h01010101 : wdata;
        sh  = 8 * int'(addr[1:0]);
        wbd = by ? ((rdata >> sh) & 32'hFF) : rdata;
        acked = 1'b0;

        @(negedge clk);
        chk("idle_ready", op_ready, 1);
        chk("idle_stall", stall, 0);
        chk("idle_req", mem_req, 0);
        op_valid = 1'b1; op_load = ld; op_byte = by;
        op_addr = addr; op_wdata = wdata; op_rd = rd;
        @(negedge clk);
        op_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (!by && addr[1:0] != 2'b00) begin
            chk("af_pulse", align_fault, 1);
            chk("af_ready", op_ready, 1);
            chk("af_req", mem_req, 0);
            chk("af_wb", wb_valid, 0);
            @(negedge clk);
            chk("af_clear", align_fault, 0);
            chk("af_req2", mem_req, 0);
            return;
        end
`endif
        for (int k = 1; k <= TO; k++) begin
            chk("req_req", mem_req, 1);
            chk("req_stall", stall, 1);
            chk("req_ready", op_ready, 0);
            chk("req_we", mem_we, !ld);
            chk("req_be", mem_be, be);
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            if (!ld) chk("req_wdata", mem_wdata, wd);
            chk("req_wb", wb_valid, 0);
            chk("req_to", mem_timeout, 0);
            mem_ack   = (k == ack_at);
            mem_rdata = mem_ack ? rdata : $urandom;
            // Stray ops while busy must be ignored; drop before the unit goes idle.
            op_valid  = !(k == ack_at || k == TO);
            op_load   = 1'($urandom); op_byte = 1'($urandom);
            op_addr   = $urandom; op_wdata = $urandom; op_rd = 4'($urandom);
            @(negedge clk);
            mem_ack  = 1'b0;
            op_valid = 1'b0;
            if (k == ack_at) begin
                acked = 1'b1;
                break;
            end
        end

        if (acked && ld) begin
            chk("ld_wbv", wb_valid, 1);
            chk("ld_wbrd", wb_rd, rd);
            chk("ld_wbdata", wb_data, wbd);
            chk("ld_stall", stall, 1);
            chk("ld_req", mem_req, 0);
            chk("ld_to", mem_timeout, 0);
            mem_ack = 1'($urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("ld_wb_once", wb_valid, 0);
            chk("ld_ready", op_ready, 1);
            chk("ld_req2", mem_req, 0);
        end else if (acked) begin
            chk("st_ready", op_ready, 1);
            chk("st_req", mem_req, 0);
            chk("st_wb", wb_valid, 0);
            chk("st_to", mem_timeout, 0);
        end else begin
            chk("to_pulse", mem_timeout, 1);
            chk("to_req", mem_req, 0);
            chk("to_ready", op_ready, 1);
            chk("to_wb", wb_valid, 0);
            @(negedge clk);
            chk("to_clear", mem_timeout, 0);
            chk("to_wb2", wb_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        op_valid = 1'b0; op_load = 1'b0; op_byte = 1'b0;
        op_addr = 32'd0; op_wdata = 32'd0; op_rd = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_to", mem_timeout, 0);
        rst = 1'b0;

        do_op(1'b0, 1'b0, 32'h104, 32'hDEADBEEF, 4'd0, 3, 32'd0);
        do_op(1'b1, 1'b1, 32'h203, 32'd0, 4'd5, 1, 32'hAA112233);
        do_op(1'b0, 1'b1, 32'h11, 32'h12345677, 4'd0, 1, 32'd0);
        do_op(1'b1, 1'b0, 32'h400, 32'd0, 4'd7, 0, 32'h0);
        do_op(1'b1, 1'b0, 32'h400, 32'd0, 4'd7, TO, 32'hCAFEF00D);
        do_op(1'b0, 1'b0, 32'h500, 32'h01020304, 4'd0, 0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        do_op(1'b1, 1'b0, 32'h102, 32'd0, 4'd3, 1, 32'h55667788);
`endif

        // Reset in the middle of a transfer.
        @(negedge clk);
        op_valid = 1'b1; op_load = 1'b1; op_byte = 1'b0;
        op_addr = 32'h300; op_rd = 4'd9;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mid_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_wb", wb_valid, 0);
        chk("mid_rst_ready", op_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_wb", wb_valid, 0);
        chk("post_rst_ready", op_ready, 1);
        do_op(1'b1, 1'b1, 32'h301, 32'd0, 4'd2, 2, 32'h00C30000 | 32'h0000A500);

        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom),
                  $urandom_range(0, TO + 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller that issues LDR/STR transfers to the data memory and returns load results to the LDR writeback stage.
- Accepts one decoded memory op from the execute stage, runs a req/ack handshake with data memory, and holds the pipeline stall for the whole transfer.
- Supports word and byte (B bit) transfers.
- Presents load data as a one-cycle writeback pulse.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ without ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- op_valid  input  1  memory op presented by execute stage
- op_load  input  1  1 = LDR, 0 = STR
- op_byte  input  1  1 = byte transfer, 0 = word
- op_addr  input  32  effective address
- op_wdata  input  32  store data (Rd value)
- op_rd  input  4  destination register for loads
- op_ready  output  1  unit idle, op accepted this cycle if op_valid
- stall  output  1  freeze upstream stages
- mem_req  output  1  data memory request
- mem_we  output  1  1 = write
- mem_be  output  4  byte lane enables
- mem_addr  output  32  word-aligned address
- mem_wdata  output  32  write data
- mem_ack  input  1  memory completes the transfer this cycle
- mem_rdata  input  32  read data, valid when mem_ack=1
- wb_valid  output  1  one-cycle load-result pulse (drives writeback enable)
- wb_rd  output  4  load destination register
- wb_data  output  32  load result
- mem_timeout  output  1  one-cycle pulse on aborted transfer
- align_fault  output  1  only with MEM_ALIGN_CHECK_EN

Behaviour:
- Reset: async. State goes to IDLE. All outputs are 0 except op_ready=1. Counter and latched op are cleared. Reset mid-transfer drops mem_req immediately; no wb_valid follows.
- States:
  - IDLE:
    - op_ready=1, stall=0.
    - op_valid=1 latches op_* and goes to REQ.
  - REQ:
    - mem_req=1, stall=1.
    - mem_addr, mem_we, mem_be and mem_wdata stay stable until ack.
    - mem_ack=1 with a load: capture data and go to RESP.
    - mem_ack=1 with a store: go to IDLE.
  - RESP:
    - wb_valid=1 for exactly one cycle with wb_rd/wb_data; stall=1.
    - Next state is IDLE.
- Latency:
  - Op accepted at cycle T; mem_req=1 from T+1.
  - Ack is allowed at T+1.
  - Load: ack at cycle A gives wb_valid at A+1.
  - Store: op_ready=1 again at A+1.
  - Minimum issue interval: store 2 cycles, load 3 cycles.
- Outputs are registered except op_ready and stall, which decode state combinationally. stall=1 whenever state != IDLE.
- Addressing and lanes:
  - mem_addr = {op_addr[31:2], 2'b00}.
  - Word: mem_be = 4'b1111; mem_wdata = op_wdata.
  - Byte: mem_be = 4'b0001 << op_addr[1:0]; mem_wdata = op_wdata[7:0] replicated ×4.
  - Load byte: wb_data = zero-extended mem_rdata lane op_addr[1:0]. Load word: wb_data = mem_rdata.
- Timeout:
  - 8-bit wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - If the count reaches TIMEOUT_CYCLES: mem_req drops, mem_timeout pulses one cycle, state goes to IDLE, no wb_valid.
  - mem_ack in the same cycle as the limit: ack wins, normal completion.
- Boundary cases:
  - mem_ack outside REQ is ignored.
  - op_valid while not IDLE is ignored; upstream holds the op via stall.
  - mem_rdata is sampled only on an ack in REQ.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A word op with op_addr[1:0] != 0 is accepted but not issued; mem_req stays 0.
  - align_fault pulses one cycle at T+1, no wb_valid, and state returns to IDLE at T+1.
  - Byte ops are never faulted.
- Undefined:
  - align_fault port is absent.
  - op_addr[1:0] is ignored for word ops; the transfer is issued to the aligned word.

Test Plan:
- Word store: op_addr=0x104, wdata=0xDEADBEEF, ack on 3rd REQ cycle -> mem_req 3 cycles, mem_we=1, be=1111, mem_addr=0x104; stall=1 throughout; no wb_valid.
- Byte load: op_addr=0x203, rd=5, mem_rdata=0xAA112233 with ack at T+1 -> mem_be=1000, wb_valid at T+2, wb_rd=5, wb_data=0x000000AA.
- Byte store: op_addr=0x11, wdata=0x12345677 -> mem_be=0010, mem_wdata=0x77777777, mem_addr=0x10.
- Timeout (TIMEOUT_CYCLES=4), load, no ack -> mem_req high 4 cycles, mem_timeout single pulse, op_ready=1 next cycle, wb_valid never set; repeat with ack on the 4th cycle -> normal completion, no timeout.
- Reset mid-transfer: assert rst during REQ -> mem_req, stall, wb_valid=0 immediately; a later mem_ack is ignored; a new op is accepted after release.
- With MEM_ALIGN_CHECK_EN, word load at 0x102 -> no mem_req, align_fault pulse at T+1, op_ready=1 at T+1.
